// File: rtl/intra4x4_sched_if.sv
// Handshake and block-coordinate bundle between the 4x4 intra sequencer and its datapath.
// The master modport is the sequencer's view; slave is the datapath/environment view.
interface intra4x4_sched_if;
  logic        start;
  logic        pred_done;
  logic        recon_done;
  logic [2:0]  mode_in;
  logic        busy;
  logic        done;
  logic        pred_start;
  logic        save_en;
  logic        recon_start;
  logic [3:0]  blk_idx;
  logic [1:0]  blk_x;
  logic [1:0]  blk_y;
  logic [8:0]  mb_x;
  logic [8:0]  mb_y;
  logic [12:0] mbnumber;
  logic        top_avail;
  logic        left_avail;
  logic        topright_avail;
  logic [2:0]  last_mode;

  modport master (
    input  start, pred_done, recon_done, mode_in,
    output busy, done, pred_start, save_en, recon_start, blk_idx, blk_x, blk_y,
           mb_x, mb_y, mbnumber, top_avail, left_avail, topright_avail, last_mode
  );

  modport slave (
    output start, pred_done, recon_done, mode_in,
    input  busy, done, pred_start, save_en, recon_start, blk_idx, blk_x, blk_y,
           mb_x, mb_y, mbnumber, top_avail, left_avail, topright_avail, last_mode
  );
endinterface

// File: rtl/intra4x4_sched.sv
// Luma 4x4 intra-prediction sequencer: walks macroblocks in raster order and sub-blocks in
// z-order, serialising predict -> save -> reconstruct for each 4x4 block.
module intra4x4_sched #(
  parameter int unsigned LENGTH = 256,
  parameter int unsigned WIDTH  = 256
) (
  input logic              clk,
  input logic              reset,
  intra4x4_sched_if.master bus
);

  localparam int unsigned MbsX    = WIDTH / 16;
  localparam int unsigned MbsY    = LENGTH / 16;
  localparam logic [8:0]  MbxLast = 9'(MbsX - 1);
  localparam logic [8:0]  MbyLast = 9'(MbsY - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitPred, StSave, StRecon, StWaitRecon, StDone
  } state_e;

  state_e      state_q;
  logic        busy_q, done_q, pred_start_q, save_en_q, recon_start_q;
  logic [3:0]  blk_q;
  logic [8:0]  mb_x_q, mb_y_q;
  logic [12:0] mbnum_q;
  logic [2:0]  last_mode_q;

  logic [1:0]  blk_x, blk_y, nbr_x, nbr_y;
  logic [3:0]  nbr_idx;
  logic        topright;
  logic        last_blk;

  assign blk_x    = {blk_q[2], blk_q[0]};
  assign blk_y    = {blk_q[3], blk_q[1]};
  assign last_blk = (blk_q == 4'd15) && (mb_x_q == MbxLast) && (mb_y_q == MbyLast);

  // Top-right neighbour inside the MB is available only if it precedes us in z-order.
  always_comb begin
    nbr_x    = blk_x + 2'd1;
    nbr_y    = blk_y - 2'd1;
    nbr_idx  = {nbr_y[1], nbr_x[1], nbr_y[0], nbr_x[0]};
    topright = 1'b0;
    if (blk_y == 2'd0) begin
      topright = (mb_y_q != 9'd0) && ((blk_x != 2'd3) || (mb_x_q != MbxLast));
    end else if (blk_x == 2'd3) begin
      topright = 1'b0;
    end else begin
      topright = nbr_idx < blk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pred_start_q  <= 1'b0;
      save_en_q     <= 1'b0;
      recon_start_q <= 1'b0;
      blk_q         <= 4'd0;
      mb_x_q        <= 9'd0;
      mb_y_q        <= 9'd0;
      mbnum_q       <= 13'd0;
      last_mode_q   <= 3'd0;
    end else begin
      pred_start_q  <= 1'b0;
      save_en_q     <= 1'b0;
      recon_start_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q      <= StIssue;
            busy_q       <= 1'b1;
            pred_start_q <= 1'b1;
            blk_q        <= 4'd0;
            mb_x_q       <= 9'd0;
            mb_y_q       <= 9'd0;
            mbnum_q      <= 13'd0;
          end
        end
        StIssue: state_q <= StWaitPred;
        StWaitPred: begin
          if (bus.pred_done) begin
            state_q   <= StSave;
            save_en_q <= 1'b1;
          end
        end
        StSave: begin
          state_q       <= StRecon;
          recon_start_q <= 1'b1;
        end
        StRecon: begin
          state_q     <= StWaitRecon;
          last_mode_q <= bus.mode_in;
        end
        StWaitRecon: begin
          if (bus.recon_done) begin
            if (last_blk) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q      <= StIssue;
              pred_start_q <= 1'b1;
              blk_q        <= blk_q + 4'd1;
              if (blk_q == 4'd15) begin
                mbnum_q <= mbnum_q + 13'd1;
                if (mb_x_q == MbxLast) begin
                  mb_x_q <= 9'd0;
                  mb_y_q <= mb_y_q + 9'd1;
                end else begin
                  mb_x_q <= mb_x_q + 9'd1;
                end
              end
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pred_start     = pred_start_q;
  assign bus.save_en        = save_en_q;
  assign bus.recon_start    = recon_start_q;
  assign bus.blk_idx        = blk_q;
  assign bus.blk_x          = blk_x;
  assign bus.blk_y          = blk_y;
  assign bus.mb_x           = mb_x_q;
  assign bus.mb_y           = mb_y_q;
  assign bus.mbnumber       = mbnum_q;
  assign bus.top_avail      = (blk_y != 2'd0) || (mb_y_q != 9'd0);
  assign bus.left_avail     = (blk_x != 2'd0) || (mb_x_q != 9'd0);
  assign bus.topright_avail = topright;
  assign bus.last_mode      = last_mode_q;

endmodule

// File: tb/tb_intra4x4_sched.sv
// Directed bench: a 32x32 instance for frame timing and handshakes, a default-size instance
// for MB-edge availability, mid-frame reset and start-while-busy.
module tb_intra4x4_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intra4x4_sched_if bus_s ();
  intra4x4_sched_if bus_b ();

  intra4x4_sched #(.LENGTH(32), .WIDTH(32)) u_small (.clk(clk), .reset(reset), .bus(bus_s));
  intra4x4_sched u_big (.clk(clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived MB0 expectations indexed by z-order index.
  int          bx_tab[16] = '{0, 1, 0, 1, 2, 3, 2, 3, 0, 1, 0, 1, 2, 3, 2, 3};
  int          by_tab[16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
  logic [15:0] top_mask   = 16'hFFCC;
  logic [15:0] left_mask  = 16'hFAFA;
  logic [15:0] tr_mask    = 16'h5744;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  cyc, k, np, ns, nr, nd, done_cyc;
  bit  got_done, hit_a, hit_b, hit_c, hit_r;

  initial begin
    reset = 1'b1;
    bus_s.start = 1'b0; bus_s.pred_done = 1'b0; bus_s.recon_done = 1'b0; bus_s.mode_in = 3'd0;
    bus_b.start = 1'b0; bus_b.pred_done = 1'b0; bus_b.recon_done = 1'b0; bus_b.mode_in = 3'd0;
    step();
    step();
    check("rst_busy", 32'(bus_s.busy), 0);
    check("rst_pulses", 32'({bus_s.pred_start, bus_s.save_en, bus_s.recon_start, bus_s.done}), 0);
    check("rst_blk", 32'(bus_s.blk_idx), 0);
    check("rst_avail", 32'({bus_s.top_avail, bus_s.left_avail, bus_s.topright_avail}), 0);
    check("rst_big_mbnum", 32'(bus_b.mbnumber), 0);
    reset = 1'b0;
    step();

    // Full 32x32 frame with handshakes tied high; MB0 z-order sweep on the way.
    bus_s.pred_done = 1'b1; bus_s.recon_done = 1'b1;
    bus_s.start = 1'b1;
    step();
    bus_s.start = 1'b0;
    cyc = 1; k = 0; np = 0; ns = 0; nr = 0; nd = 0; got_done = 0; done_cyc = 0;
    check("busy_after_start", 32'(bus_s.busy), 1);
    while (!got_done && cyc < 1000) begin
      if (bus_s.pred_start) begin
        np++;
        if (k < 16) begin
          check("sweep_idx", 32'(bus_s.blk_idx), k);
          check("sweep_x", 32'(bus_s.blk_x), bx_tab[k]);
          check("sweep_y", 32'(bus_s.blk_y), by_tab[k]);
          check("sweep_top", 32'(bus_s.top_avail), 32'(top_mask[k]));
          check("sweep_left", 32'(bus_s.left_avail), 32'(left_mask[k]));
          check("sweep_tr", 32'(bus_s.topright_avail), 32'(tr_mask[k]));
        end
        if (k == 16) check("mb1_mbnum", 32'(bus_s.mbnumber), 1);
        k++;
      end
      if (bus_s.save_en) ns++;
      if (bus_s.recon_start) nr++;
      if (bus_s.done) begin
        got_done = 1;
        done_cyc = cyc;
        nd++;
      end
      if (!got_done) begin
        step();
        cyc++;
      end
    end
    check("done_seen", 32'(got_done), 1);
    check("done_cycle", done_cyc, 321);
    check("n_pred_start", np, 64);
    check("n_save_en", ns, 64);
    check("n_recon_start", nr, 64);
    check("busy_at_done", 32'(bus_s.busy), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_s.done) nd++;
    end
    check("done_once", nd, 1);
    check("busy_after_done", 32'(bus_s.busy), 0);

    // Delayed pred_done, spurious recon_done, and last_mode capture.
    bus_s.pred_done = 1'b0; bus_s.recon_done = 1'b0;
    bus_s.start = 1'b1;
    step();
    bus_s.start = 1'b0;
    check("hs_issue", 32'(bus_s.pred_start), 1);
    check("hs_idx0", 32'(bus_s.blk_idx), 0);
    bus_s.recon_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hs_hold_save", 32'(bus_s.save_en), 0);
      check("hs_hold_recon", 32'(bus_s.recon_start), 0);
      check("hs_hold_stable", 32'({bus_s.blk_idx, bus_s.busy, bus_s.pred_start}), 32'({4'd0, 1'b1, 1'b0}));
    end
    bus_s.recon_done = 1'b0;
    bus_s.pred_done = 1'b1;
    bus_s.mode_in = 3'd5;
    step();
    bus_s.pred_done = 1'b0;
    check("hs_save_en", 32'(bus_s.save_en), 1);
    step();
    check("hs_recon_start", 32'(bus_s.recon_start), 1);
    check("hs_mode_not_yet", 32'(bus_s.last_mode), 0);
    step();
    bus_s.mode_in = 3'd2;
    check("hs_last_mode", 32'(bus_s.last_mode), 5);
    check("hs_recon_single", 32'(bus_s.recon_start), 0);
    step();
    check("hs_wait_recon", 32'({bus_s.pred_start, bus_s.blk_idx}), 0);
    bus_s.recon_done = 1'b1;
    step();
    bus_s.recon_done = 1'b0;
    check("hs_next_issue", 32'(bus_s.pred_start), 1);
    check("hs_next_idx", 32'(bus_s.blk_idx), 1);
    check("hs_mode_held", 32'(bus_s.last_mode), 5);

    // Default-size frame: start while busy, then reset at block 7 of MB 2.
    bus_b.pred_done = 1'b1; bus_b.recon_done = 1'b1;
    bus_b.start = 1'b1;
    step();
    step();
    check("bb_start_busy_wait", 32'(bus_b.save_en), 0);
    step();
    bus_b.start = 1'b0;
    check("bb_start_busy_save", 32'(bus_b.save_en), 1);
    check("bb_start_busy_idx", 32'(bus_b.blk_idx), 0);
    hit_r = 0;
    for (int c = 0; c < 1000 && !hit_r; c++) begin
      step();
      if (bus_b.pred_start && bus_b.mb_x == 9'd2 && bus_b.blk_idx == 4'd7) hit_r = 1;
    end
    check("bb_reached_mb2_b7", 32'(hit_r), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", 32'(bus_b.busy), 0);
    check("mid_rst_pulses", 32'({bus_b.pred_start, bus_b.save_en, bus_b.recon_start, bus_b.done}), 0);
    check("mid_rst_ctrs", 32'({bus_b.blk_idx, bus_b.mb_x, bus_b.mbnumber}), 0);
    step();
    check("post_rst_pulses", 32'({bus_b.pred_start, bus_b.save_en, bus_b.recon_start, bus_b.done}), 0);
    check("post_rst_idle", 32'(bus_b.busy), 0);
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    check("restart_issue", 32'(bus_b.pred_start), 1);
    check("restart_pos", 32'({bus_b.blk_idx, bus_b.mb_x, bus_b.mb_y}), 0);

    // Right-edge top-right availability and mbnumber in the second MB row.
    hit_a = 0; hit_b = 0; hit_c = 0;
    for (int c = 0; c < 4000 && bus_b.mbnumber != 13'd32; c++) begin
      if (bus_b.pred_start && bus_b.mb_y == 9'd1) begin
        if (bus_b.mb_x == 9'd15 && bus_b.blk_idx == 4'd5) begin
          hit_a = 1;
          check("tr_mb15_1_idx5", 32'(bus_b.topright_avail), 0);
        end
        if (bus_b.mb_x == 9'd14 && bus_b.blk_idx == 4'd5) begin
          hit_b = 1;
          check("tr_mb14_1_idx5", 32'(bus_b.topright_avail), 1);
        end
        if (bus_b.mb_x == 9'd1 && bus_b.blk_idx == 4'd0) begin
          hit_c = 1;
          check("mbnum_mb1_1", 32'(bus_b.mbnumber), 17);
        end
      end
      step();
    end
    check("hit_mb15_1", 32'(hit_a), 1);
    check("hit_mb14_1", 32'(hit_b), 1);
    check("hit_mb1_1", 32'(hit_c), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
